mem_access: RTL and testbench



---
 rtl/mem_pkg.sv | 78 +++++++
 rtl/mem_lane_align.sv | 72 +++++++
 rtl/mem_access.sv | 199 +++++++++++++++++++
 tb/tb_mem_access.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the memory ALUop encodings, the transaction state type, the access
// size type and small decode helpers used by mem_access and mem_lane_align.
package mem_pkg;

    localparam logic [4:0] OP_LB  = 5'b10000;
    localparam logic [4:0] OP_LH  = 5'b10001;
    localparam logic [4:0] OP_LW  = 5'b10010;
    localparam logic [4:0] OP_LBU = 5'b10011;
    localparam logic [4:0] OP_LHU = 5'b10100;
    localparam logic [4:0] OP_SB  = 5'b10101;
    localparam logic [4:0] OP_SH  = 5'b10110;
    localparam logic [4:0] OP_SW  = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_t;

    function automatic logic is_load(input logic [4:0] op);
        logic res;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: res = 1'b1;
            default:                             res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        logic res;
        case (op)
            OP_SB, OP_SH, OP_SW: res = 1'b1;
            default:             res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_unsigned_load(input logic [4:0] op);
        logic res;
        case (op)
            OP_LBU, OP_LHU: res = 1'b1;
            default:        res = 1'b0;
        endcase
        return res;
    endfunction

    // SZ_NONE doubles as "not a memory operation".
    function automatic size_t op_size(input logic [4:0] op);
        size_t res;
        case (op)
            OP_LB, OP_LBU, OP_SB: res = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: res = SZ_HALF;
            OP_LW, OP_SW:         res = SZ_WORD;
            default:              res = SZ_NONE;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [4:0] op, input logic [1:0] addr_lo);
        logic res;
        case (op_size(op))
            SZ_HALF: res = addr_lo[0];
            SZ_WORD: res = (addr_lo != 2'b00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory stage.
// Ports:
//   op         - memory ALUop (selects access size and signedness)
//   addr_lo    - byte offset within the word
//   store_data - raw store value from rs2
//   rdata      - word returned by the data memory
//   be         - byte enables for the bus
//   wdata      - lane-replicated store data
//   load_data  - selected and extended load value
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte enables and replicated store data; replication lets the memory
    // pick the value from whichever lane the enables select.
    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        case (op_size(op))
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    // Lane selection and sign/zero extension of the returned word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (op_size(op))
            SZ_BYTE: load_data = is_unsigned_load(op) ? {24'h000000, byte_s}
                                                      : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: load_data = is_unsigned_load(op) ? {16'h0000, half_s}
                                                      : {{16{half_s[15]}}, half_s};
            SZ_WORD: load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage downstream of EX: runs loads/stores on a req/gnt/rvalid bus,
// stalls the core while a transaction is outstanding and then presents the
// write-back to the register file. Non-memory ops pass straight through.
// Ports:
//   clk, rst                       - clock, asynchronous active-low reset
//   ALUop_i .. StoreData_i         - instruction fields from EX
//   WriteReg_o/WriteDataNum_o/WriteData_o - register file write-back
//   Stall_o                        - hold PC / fetch while busy
//   Misalign_o, BusErr_o           - one-cycle fault flags
//   dmem_*                         - data memory bus
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ALUop_i,
    input  logic        WriteReg_i,
    input  logic [4:0]  WriteDataNum_i,
    input  logic [31:0] WriteData_i,
    input  logic [31:0] MemAddr_i,
    input  logic [31:0] StoreData_i,
    output logic        WriteReg_o,
    output logic [4:0]  WriteDataNum_o,
    output logic [31:0] WriteData_o,
    output logic        Stall_o,
    output logic        Misalign_o,
    output logic        BusErr_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [4:0]         op_r;
    logic [31:0]        addr_r;
    logic [4:0]         rd_r;
    logic               we_r;
    logic [31:0]        sdata_r;
    logic [31:0]        rdata_r;
    logic               err_r;

    logic               mem_op_s;
    logic               misalign_s;
    logic               start_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               timeout_s;
    logic [31:0]        load_data_s;

    assign mem_op_s   = (op_size(ALUop_i) != SZ_NONE);
    assign misalign_s = mem_op_s && is_misaligned(ALUop_i, MemAddr_i[1:0]);
    assign start_s    = mem_op_s && !misalign_s;
    assign cnt_inc_s  = cnt_r + CNT_W'(1);
    // Fires on the last allowed cycle so the abort lands exactly on the budget.
    assign timeout_s  = (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES));

    mem_lane_align u_align (
        .op         (op_r),
        .addr_lo    (addr_r[1:0]),
        .store_data (sdata_r),
        .rdata      (rdata_r),
        .be         (dmem_be_o),
        .wdata      (dmem_wdata_o),
        .load_data  (load_data_s)
    );

    // Bus address/direction come only from captured state, so they stay stable until gnt.
    assign dmem_addr_o = {addr_r[31:2], 2'b00};
    assign dmem_we_o   = is_store(op_r);

    // Transaction FSM with timeout counter and capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            op_r    <= 5'd0;
            addr_r  <= 32'd0;
            rd_r    <= 5'd0;
            we_r    <= 1'b0;
            sdata_r <= 32'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    err_r <= 1'b0;
                    if (start_s) begin
                        op_r    <= ALUop_i;
                        addr_r  <= MemAddr_i;
                        rd_r    <= WriteDataNum_i;
                        we_r    <= WriteReg_i;
                        sdata_r <= StoreData_i;
                        state_r <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        cnt_r <= '0;
                        if (is_store(op_r)) begin
                            state_r <= DONE;
                        end else if (dmem_rvalid_i) begin
                            rdata_r <= dmem_rdata_i;
                            state_r <= DONE;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else if (timeout_s) begin
                        cnt_r   <= '0;
                        err_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        cnt_r   <= '0;
                        rdata_r <= dmem_rdata_i;
                        state_r <= DONE;
                    end else if (timeout_s) begin
                        cnt_r   <= '0;
                        err_r   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                DONE: begin
                    // Upstream retires on this edge, so IDLE sees the next instruction.
                    cnt_r   <= '0;
                    err_r   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    cnt_r   <= '0;
                    err_r   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output decode: pass-through and fault/stall flags in IDLE, write-back in DONE.
    always_comb begin
        WriteReg_o     = 1'b0;
        WriteDataNum_o = rd_r;
        WriteData_o    = load_data_s;
        Stall_o        = 1'b0;
        Misalign_o     = 1'b0;
        BusErr_o       = 1'b0;
        dmem_req_o     = 1'b0;
        if (!rst) begin
            // Reset forces every control output low regardless of inputs.
            WriteReg_o = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!mem_op_s) begin
                        WriteReg_o     = WriteReg_i;
                        WriteDataNum_o = WriteDataNum_i;
                        WriteData_o    = WriteData_i;
                    end else if (misalign_s) begin
                        Misalign_o = 1'b1;
                    end else begin
                        Stall_o = 1'b1;
                    end
                end
                REQ: begin
                    dmem_req_o = 1'b1;
                    Stall_o    = 1'b1;
                end
                WAIT: begin
                    Stall_o = 1'b1;
                end
                DONE: begin
                    if (err_r) begin
                        BusErr_o = 1'b1;
                    end else begin
                        WriteReg_o = we_r & is_load(op_r);
                    end
                end
                default: begin
                    Stall_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomised and directed bench for mem_access with a transaction-level
// reference model and a single per-cycle compare process.
module tb_mem_access;

    localparam int TO = 4;

    localparam logic [4:0] B_LB  = 5'b10000;
    localparam logic [4:0] B_LH  = 5'b10001;
    localparam logic [4:0] B_LW  = 5'b10010;
    localparam logic [4:0] B_LBU = 5'b10011;
    localparam logic [4:0] B_LHU = 5'b10100;
    localparam logic [4:0] B_SB  = 5'b10101;
    localparam logic [4:0] B_SH  = 5'b10110;
    localparam logic [4:0] B_SW  = 5'b10111;

    logic        clk;
    logic        rst;
    logic [4:0]  ALUop_i;
    logic        WriteReg_i;
    logic [4:0]  WriteDataNum_i;
    logic [31:0] WriteData_i;
    logic [31:0] MemAddr_i;
    logic [31:0] StoreData_i;
    logic        WriteReg_o;
    logic [4:0]  WriteDataNum_o;
    logic [31:0] WriteData_o;
    logic        Stall_o;
    logic        Misalign_o;
    logic        BusErr_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ALUop_i        (ALUop_i),
        .WriteReg_i     (WriteReg_i),
        .WriteDataNum_i (WriteDataNum_i),
        .WriteData_i    (WriteData_i),
        .MemAddr_i      (MemAddr_i),
        .StoreData_i    (StoreData_i),
        .WriteReg_o     (WriteReg_o),
        .WriteDataNum_o (WriteDataNum_o),
        .WriteData_o    (WriteData_o),
        .Stall_o        (Stall_o),
        .Misalign_o     (Misalign_o),
        .BusErr_o       (BusErr_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle, set by the stimulus.
    logic        chk_en = 1'b0;
    logic        e_req, e_stall, e_mis, e_berr, e_wreg, e_chk_wb, e_we;
    logic [4:0]  e_num;
    logic [31:0] e_data, e_addr, e_wd;
    logic [3:0]  e_be;

    // Observations used by the literal checks.
    int          stall_cnt = 0;
    int          berr_cnt  = 0;
    int          mis_cnt   = 0;
    logic [31:0] seen_data, seen_addr, seen_wd;
    logic [3:0]  seen_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_bytes(input logic [4:0] op);
        case (op)
            B_LB, B_LBU, B_SB: return 1;
            B_LH, B_LHU, B_SH: return 2;
            B_LW, B_SW:        return 4;
            default:           return 0;
        endcase
    endfunction

    function automatic bit is_ld(input logic [4:0] op);
        return (op == B_LB) || (op == B_LH) || (op == B_LW) || (op == B_LBU) || (op == B_LHU);
    endfunction

    function automatic logic [3:0] model_be(input int nb, input logic [1:0] a);
        int m;
        m = (nb == 4) ? 15 : (((1 << nb) - 1) << a);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wd(input int nb, input logic [31:0] d);
        if (nb == 1) return 32'(d[7:0]) * 32'h01010101;
        if (nb == 2) return 32'(d[15:0]) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_ld(input logic [4:0] op, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] v;
        int nb;
        nb = op_bytes(op);
        v  = d >> (8 * a);
        if (nb == 1) begin
            v = v & 32'hFF;
            if (op == B_LB && v >= 32'h80) v = v - 32'h100;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (op == B_LH && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    // Per-cycle comparison of DUT outputs against the expected values.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req",     32'(dmem_req_o), 32'(e_req));
            check("stall",   32'(Stall_o),    32'(e_stall));
            check("misalign",32'(Misalign_o), 32'(e_mis));
            check("buserr",  32'(BusErr_o),   32'(e_berr));
            check("wreg",    32'(WriteReg_o), 32'(e_wreg));
            if (e_chk_wb) begin
                check("wnum",  32'(WriteDataNum_o), 32'(e_num));
                check("wdata", WriteData_o, e_data);
                seen_data = WriteData_o;
            end
            if (e_req) begin
                check("addr", dmem_addr_o, e_addr);
                check("be",   32'(dmem_be_o), 32'(e_be));
                check("we",   32'(dmem_we_o), 32'(e_we));
                if (e_we) check("bus_wdata", dmem_wdata_o, e_wd);
                seen_addr = dmem_addr_o;
                seen_be   = dmem_be_o;
                seen_wd   = dmem_wdata_o;
            end
            if (Stall_o)    stall_cnt++;
            if (BusErr_o)   berr_cnt++;
            if (Misalign_o) mis_cnt++;
        end
    end

    task automatic clear_exp();
        e_req = 0; e_stall = 0; e_mis = 0; e_berr = 0; e_wreg = 0; e_chk_wb = 0; e_we = 0;
        e_num = 5'd0; e_data = 32'd0; e_addr = 32'd0; e_wd = 32'd0; e_be = 4'd0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One instruction: g = REQ cycle index carrying gnt (>= TO means never),
    // r = 0 for rvalid with gnt, else rvalid on WAIT cycle r-1.
    task automatic run_instr(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sd,
                             input logic [31:0] wd, input logic wr, input logic [4:0] rd,
                             input int g, input int r, input logic [31:0] rdat);
        int nb;
        bit ld;
        bit to;
        nb = op_bytes(op);
        ld = is_ld(op);
        ALUop_i = op; MemAddr_i = addr; StoreData_i = sd;
        WriteData_i = wd; WriteReg_i = wr; WriteDataNum_i = rd;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'($urandom); dmem_rdata_i = $urandom;
        clear_exp();
        if (nb == 0) begin
            e_wreg = wr; e_chk_wb = 1; e_num = rd; e_data = wd;
            cycle();
            return;
        end
        if ((int'(addr[1:0]) % nb) != 0) begin
            e_mis = 1;
            cycle();
            return;
        end
        e_stall = 1;
        cycle();
        e_addr = addr & 32'hFFFF_FFFC;
        e_be   = model_be(nb, addr[1:0]);
        e_we   = !ld;
        e_wd   = model_wd(nb, sd);
        to = 1;
        for (int k = 0; k < TO; k++) begin
            e_req = 1;
            dmem_gnt_i = (k == g);
            if (k == g && ld) begin
                dmem_rvalid_i = (r == 0);
                dmem_rdata_i  = rdat;
            end else begin
                dmem_rvalid_i = 1'($urandom);
                dmem_rdata_i  = $urandom;
            end
            cycle();
            if (k == g) begin
                to = 0;
                break;
            end
        end
        e_req = 0;
        dmem_gnt_i = 1'b0;
        if (!to && ld && r != 0) begin
            to = 1;
            for (int k = 0; k < TO; k++) begin
                dmem_rvalid_i = (k == r - 1);
                dmem_rdata_i  = (k == r - 1) ? rdat : $urandom;
                cycle();
                if (k == r - 1) begin
                    to = 0;
                    break;
                end
            end
        end
        dmem_rvalid_i = 1'($urandom);
        dmem_rdata_i  = $urandom;
        e_stall  = 0;
        e_berr   = to;
        e_wreg   = !to && ld && wr;
        e_chk_wb = !to && ld;
        e_num    = rd;
        e_data   = model_ld(op, addr[1:0], rdat);
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        ALUop_i = B_LW; MemAddr_i = 32'h0; StoreData_i = 32'h0;
        WriteData_i = 32'h0; WriteReg_i = 1'b1; WriteDataNum_i = 5'd1;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        clear_exp();
        #1 rst = 1'b0;
        #1;
        check("rst_req",   32'(dmem_req_o), 32'd0);
        check("rst_stall", 32'(Stall_o),    32'd0);
        check("rst_wreg",  32'(WriteReg_o), 32'd0);
        check("rst_addr",  dmem_addr_o,     32'd0);
        check("rst_be",    32'(dmem_be_o),  32'd0);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // ADD pass-through
        run_instr(5'b00000, 32'h0, 32'h0, 32'h1234, 1'b1, 5'd3, 0, 0, 32'h0);
        check("lit_add", seen_data, 32'h0000_1234);

        // SB at lane 3, granted on first REQ cycle
        stall_cnt = 0;
        run_instr(B_SB, 32'h103, 32'hAABBCCDD, 32'h0, 1'b1, 5'd4, 0, 0, 32'h0);
        check("lit_sb_be",    32'(seen_be), 32'h8);
        check("lit_sb_wd",    seen_wd,      32'hDDDD_DDDD);
        check("lit_sb_addr",  seen_addr,    32'h0000_0100);
        check("lit_sb_stall", stall_cnt,    2);

        // LB / LBU with three WAIT cycles before rvalid
        run_instr(B_LB, 32'h102, 32'h0, 32'h0, 1'b1, 5'd5, 0, 4, 32'h0080_0000);
        check("lit_lb", seen_data, 32'hFFFF_FF80);
        run_instr(B_LBU, 32'h102, 32'h0, 32'h0, 1'b1, 5'd6, 0, 4, 32'h0080_0000);
        check("lit_lbu", seen_data, 32'h0000_0080);

        // Misaligned word load
        mis_cnt = 0;
        run_instr(B_LW, 32'h206, 32'h0, 32'h0, 1'b1, 5'd7, 0, 0, 32'h0);
        check("lit_mis", mis_cnt, 1);

        // Grant never arrives: timeout abort
        stall_cnt = 0; berr_cnt = 0;
        run_instr(B_LW, 32'h300, 32'h0, 32'h0, 1'b1, 5'd8, 99, 0, 32'h0);
        check("lit_to_berr",  berr_cnt,  1);
        check("lit_to_stall", stall_cnt, 5);

        // Grant on the last permitted REQ cycle still completes
        run_instr(B_LHU, 32'h402, 32'h0, 32'h0, 1'b1, 5'd9, TO - 1, 0, 32'hBEEF_1234);
        check("lit_lhu", seen_data, 32'h0000_BEEF);

        // Reset while a load waits for rvalid
        clear_exp();
        ALUop_i = B_LH; MemAddr_i = 32'h102; WriteReg_i = 1'b1; WriteDataNum_i = 5'd10;
        e_stall = 1;
        cycle();
        e_req = 1; e_addr = 32'h100; e_be = 4'b1100; e_we = 0;
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
        cycle();
        e_req = 0; dmem_gnt_i = 1'b0;
        cycle();
        rst = 1'b0;
        clear_exp();
        #1;
        check("rstw_req",   32'(dmem_req_o), 32'd0);
        check("rstw_stall", 32'(Stall_o),    32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        ALUop_i = 5'd0; WriteReg_i = 1'b0; WriteDataNum_i = 5'd11; WriteData_i = 32'h5555_0000;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        e_chk_wb = 1; e_num = 5'd11; e_data = 32'h5555_0000;
        cycle();
        WriteReg_i = 1'b1;
        e_wreg = 1;
        cycle();
        dmem_rvalid_i = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            logic [4:0]  op;
            logic [31:0] addr;
            if ($urandom_range(0, 9) < 7) op = 5'b10000 + 5'($urandom_range(0, 7));
            else                          op = 5'($urandom_range(0, 31));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
            run_instr(op, addr, $urandom, $urandom, 1'($urandom), 5'($urandom),
                      $urandom_range(0, 5), $urandom_range(0, 5), $urandom);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
